// File: rtl/fetch_pc.sv
// Program counter and next-PC selector for the P4 single-cycle CPU front end.
// Define FETCH_PC_CNT_EN to build the committed-advance counter on instr_cnt.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc4,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        addr_err,
  output logic [31:0] instr_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [1:0] OP_SEQ = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_J   = 2'b10;
  localparam logic [1:0] OP_JR  = 2'b11;

  state_t             state;
  logic signed [31:0] br_off;
  logic [31:0]        npc;
  logic               jr_misaligned;
  logic               commit;

  // Word offset scaled to bytes; two's-complement add wraps naturally below 0.
  assign br_off        = {{14{imm16[15]}}, imm16, 2'b00};
  assign jr_misaligned = (npc_op == OP_JR) && (rs_val[1:0] != 2'b00);
  assign commit        = (state == RUN) && !stall && !jr_misaligned;

  always_comb begin
    npc = pc4;
    case (npc_op)
      OP_SEQ: npc = pc4;
      OP_BR:  npc = branch_taken ? (pc4 + $unsigned(br_off)) : pc4;
      OP_J:   npc = {pc[31:28], instr_index, 2'b00};
      OP_JR:  npc = rs_val;
      default: npc = pc4;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (!stall) begin
            if (jr_misaligned) begin
              state       <= HALT;
              fetch_valid <= 1'b0;
              addr_err    <= 1'b1;
            end else begin
              pc <= npc;
            end
          end
        end
        HALT: begin
          fetch_valid <= 1'b0;
          addr_err    <= 1'b1;
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PC_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_cnt <= '0;
    end else if (commit) begin
      instr_cnt <= instr_cnt + 32'd1;
    end
  end
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Program-counter register and next-PC selector at the front of the P4 single-cycle CPU. It holds the current fetch address and drives it to the instruction memory and to the PC+4 adder. Each cycle it takes the adder's PC+4 result back in, together with the branch, jump and jr information from decode. It commits the next PC on the rising clock edge and halts with an error flag if a jr target is misaligned.

## Interface
- RESET_PC, 32'h0000_3000, fetch address loaded by reset.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- pc4  in  32  PC+4 from the adder; the block does not check it against pc.
- stall  in  1  hold PC this cycle.
- npc_op  in  2  next-PC source:
  - 00 sequential
  - 01 beq-type branch
  - 10 j/jal
  - 11 jr
- branch_taken  in  1  comparator result; only meaningful when npc_op=01.
- imm16  in  16  branch offset in words.
- instr_index  in  26  J-type target field.
- rs_val  in  32  jr target.
- pc  out  32  current fetch address.
- fetch_valid  out  1  pc holds an instruction to execute this cycle.
- addr_err  out  1  sticky misaligned-target error.
- instr_cnt  out  32  count of committed PC advances; exists only with FETCH_PC_CNT_EN.

## Operation
- States:
  - BOOT: entered by reset; pc=RESET_PC; fetch_valid=0; all inputs ignored; moves to RUN on the next rising edge.
  - RUN: fetch_valid=1; pc updates every edge per the rules below.
  - HALT: fetch_valid=0; addr_err=1; pc frozen. Only reset leaves HALT.
- Next-PC candidates, all computed mod 2^32:
  - sequential: pc4
  - branch: pc4 + (sign_extend(imm16) << 2)
  - jump: {pc[31:28], instr_index, 2'b00}
  - jr: rs_val
- npc_op=01 with branch_taken=0 selects the sequential candidate.
- Priority in RUN:
  1. stall=1: pc holds, no error check, counter holds.
  2. npc_op=11 and rs_val[1:0]≠0: pc holds, go to HALT, addr_err set.
  3. Otherwise: pc ← selected candidate; counter increments.
- Reset values: pc=RESET_PC, fetch_valid=0, addr_err=0, instr_cnt=0, state=BOOT.
- Boundaries:
  - pc4 wraps to 0 when pc=32'hFFFF_FFFC; the wrapped value is committed as-is.
  - A negative branch offset may wrap below 0; the result is used without error.
  - instr_cnt wraps from 32'hFFFF_FFFF to 0.
  - Branch and jump targets are word-aligned by construction; only jr is checked.
- Reset asserted mid-operation forces reset values immediately (asynchronous). This applies in any state, including HALT.

## Timing
- pc is a registered output.
- Next-PC selection is combinational from the current cycle's inputs.
- Inputs must be stable before the rising edge. The new pc is visible after that edge (1-cycle latency).
- Reset release: the first rising edge after reset_n goes high moves BOOT→RUN with pc=RESET_PC still held. The second edge is the first possible pc change.
- addr_err and HALT take effect on the same edge the misaligned jr would have committed.
- Stall is honoured on the edge it is sampled; there are no pending or queued updates.

## Configuration
- FETCH_PC_CNT_EN defined:
  - instr_cnt is a 32-bit register.
  - It is cleared by reset and increments on every committed PC update in RUN.
  - It does not increment in BOOT, HALT or on stall cycles.
- FETCH_PC_CNT_EN undefined: no counter register is built and instr_cnt is driven to constant 0.

## Test plan
- Reset and boot:
  - Stimulus: reset_n low, then high; npc_op=00 with pc4 driven as pc+4.
  - Required: pc=0x3000 and fetch_valid=0 for one cycle, then 0x3000 with fetch_valid=1, then 0x3004, then 0x3008.
  - With the macro: instr_cnt=2 after the two advances.
- Branch:
  - Stimulus: pc=0x3010, npc_op=01, imm16=16'hFFFC, branch_taken=1.
  - Required: pc=0x3004.
  - Same stimulus with branch_taken=0: pc=0x3014.
- Jump and jr:
  - j: pc=0x3020, instr_index=26'h0000C10 → pc=0x3040.
  - jr: rs_val=0x0000_3100 → pc=0x3100.
- Misaligned jr:
  - Stimulus: rs_val=0x3102, npc_op=11, stall=0.
  - Required: pc holds, addr_err=1, fetch_valid=0, and the block stays halted under any input until reset_n pulses low.
  - Same stimulus with stall=1: no error, pc holds.
- Stall and wrap:
  - stall=1 for 3 cycles: pc and instr_cnt unchanged.
  - pc=0xFFFF_FFFC with pc4=0: pc=0 and addr_err stays 0.
- Asynchronous reset mid-run:
  - Stimulus: drop reset_n between clock edges while in RUN at pc=0x3040.
  - Required: pc=0x3000, instr_cnt=0 and fetch_valid=0 immediately, without waiting for a clock edge.
